// File: rtl/ex_mem_stage_skid_pkg.sv
// Shared CPU pipeline constants: default datapath widths and control-vector bit positions.
// Reused by the ID_EX, EX_MEM and MEM_WB pipeline registers.
package ex_mem_stage_skid_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int REG_AW_DEF = 5;
    localparam int CTRL_W_DEF = 6;

    // Control vector {RegWrite, MemtoReg, Branch, MemRead, MemWrite, switch_branch}, MSB first
    localparam int CTRL_REG_WRITE     = 5;
    localparam int CTRL_MEM_TO_REG    = 4;
    localparam int CTRL_BRANCH        = 3;
    localparam int CTRL_MEM_READ      = 2;
    localparam int CTRL_MEM_WRITE     = 1;
    localparam int CTRL_SWITCH_BRANCH = 0;

    function automatic logic [1:0] count_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/ex_mem_stage_skid_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Latency: count reflects inc one edge later. Backpressure: none.
// Reset clears the count asynchronously.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage_skid.sv
// EX->MEM pipeline register with a two-entry skid buffer (main drives outputs, skid absorbs one).
// Latency: 1 cycle input to output. Backpressure: in_ready is registered !skid_valid, no comb path from out_ready.
// Flush and reset drop every held bundle; bubbles present an all-zero control vector.
module ex_mem_stage_skid
    import ex_mem_stage_skid_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_rs2,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   rs2;
    } bundle_t;

    bundle_t main_q, skid_q, in_b;
    logic    main_vld, skid_vld, rdy_q;
    logic    accept, fire;

    assign in_b   = '{ctrl: in_ctrl, rd: in_rd, imm: in_imm, alu: in_alu, rs2: in_rs2};
    assign accept = in_valid && rdy_q;
    assign fire   = main_vld && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            rdy_q    <= 1'b0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            rdy_q <= !skid_vld;
            // rdy_q mirrors skid_vld, so an accept can only coincide with an empty skid
            if (fire) begin
                if (skid_vld) begin
                    main_q   <= skid_q;
                    skid_vld <= 1'b0;
                    rdy_q    <= 1'b1;
                end else if (accept) begin
                    main_q <= in_b;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (accept) begin
                if (!main_vld) begin
                    main_q   <= in_b;
                    main_vld <= 1'b1;
                end else begin
                    skid_q   <= in_b;
                    skid_vld <= 1'b1;
                    rdy_q    <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld;
    assign out_ctrl  = main_vld ? main_q.ctrl : '0;
    assign out_rd    = main_q.rd;
    assign out_imm   = main_q.imm;
    assign out_alu   = main_q.alu;
    assign out_rs2   = main_q.rs2;
    assign occupancy = count_valid(main_vld, skid_vld);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (main_vld && !out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_ex_mem_stage_skid.sv
// Bench for ex_mem_stage_skid: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ex_mem_stage_skid;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 6;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   rs2;
    } txn_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [REG_AW-1:0] in_rd = '0;
    logic [XLEN-1:0]   in_imm = '0;
    logic [XLEN-1:0]   in_alu = '0;
    logic [XLEN-1:0]   in_rs2 = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_alu;
    logic [XLEN-1:0]   out_rs2;
    logic              flush = 1'b0;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int passed = 0;

    ex_mem_stage_skid #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_rd(in_rd), .in_imm(in_imm), .in_alu(in_alu), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_imm(out_imm), .out_alu(out_alu), .out_rs2(out_rs2),
        .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a FIFO of at most two held bundles; ready means room for another.
    txn_t      held[$];
    logic      m_rdy = 1'b0;
    int        m_stall = 0;
    logic [63:0] delivered[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            held.delete();
            m_rdy   = 1'b0;
            m_stall = 0;
        end else begin
            txn_t t;
            logic acc, fr;
            acc = in_valid && m_rdy;
            fr  = (held.size() > 0) && out_ready;
            if (held.size() > 0 && !out_ready && m_stall < (1 << CNT_W) - 1) m_stall++;
            if (flush) begin
                held.delete();
            end else begin
                if (fr) begin
                    delivered.push_back(held[0].alu);
                    void'(held.pop_front());
                end
                if (acc) begin
                    t.ctrl = in_ctrl; t.rd = in_rd; t.imm = in_imm; t.alu = in_alu; t.rs2 = in_rs2;
                    held.push_back(t);
                end
            end
            m_rdy = held.size() < 2;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {63'b0, out_valid}, {63'b0, held.size() > 0});
        chk("in_ready", {63'b0, in_ready}, {63'b0, m_rdy});
        chk("occupancy", 64'(occupancy), 64'(held.size()));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (held.size() > 0) begin
            chk("out_ctrl", 64'(out_ctrl), 64'(held[0].ctrl));
            chk("out_rd", 64'(out_rd), 64'(held[0].rd));
            chk("out_imm", out_imm, held[0].imm);
            chk("out_alu", out_alu, held[0].alu);
            chk("out_rs2", out_rs2, held[0].rs2);
        end else begin
            chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] alu);
        in_valid = v;
        in_alu   = alu;
        in_imm   = alu + 64'd100;
        in_rs2   = alu + 64'd200;
        in_rd    = alu[4:0];
        in_ctrl  = 6'b100010;
    endtask

    initial begin
        logic found;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        #1 reset = 1'b1;
        step();
        chk("post_rst_ready", {63'b0, in_ready}, 64'd1);

        // Streaming: one bundle per cycle, each visible one edge after it is offered.
        out_ready = 1'b1;
        delivered.delete();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(i));
            step();
            chk("stream_alu", out_alu, 64'(i));
            chk("stream_occ", 64'(occupancy), 64'd1);
        end
        drive(1'b0, 64'd0);
        step();
        chk("stream_n", 64'(delivered.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < delivered.size()) chk("stream_order", delivered[i], 64'(i + 1));

        // Backpressure: two held, third waits, then all drain in order.
        out_ready = 1'b0;
        delivered.delete();
        drive(1'b1, 64'hA); step();
        drive(1'b1, 64'hB); step();
        chk("bp_occ2", 64'(occupancy), 64'd2);
        chk("bp_ready0", {63'b0, in_ready}, 64'd0);
        drive(1'b1, 64'hC); step();
        chk("bp_head", out_alu, 64'hA);
        out_ready = 1'b1;
        step();
        chk("bp_skid_to_main", out_alu, 64'hB);
        step();
        drive(1'b0, 64'd0);
        step();
        chk("bp_n", 64'(delivered.size()), 64'd3);
        if (delivered.size() == 3) begin
            chk("bp_0", delivered[0], 64'hA);
            chk("bp_1", delivered[1], 64'hB);
            chk("bp_2", delivered[2], 64'hC);
        end

        // Saturation of the 4-bit stall counter.
        out_ready = 1'b0;
        drive(1'b1, 64'h55); step();
        drive(1'b0, 64'd0);
        repeat (20) step();
        chk("sat_15", 64'(stall_cnt), 64'd15);
        repeat (3) step();
        chk("sat_hold", 64'(stall_cnt), 64'd15);

        // Flush with two held and a simultaneous offer, then with one held and an accepted offer.
        delivered.delete();
        drive(1'b1, 64'h11); step();
        chk("fl_occ2", 64'(occupancy), 64'd2);
        drive(1'b1, 64'hD); flush = 1'b1;
        step();
        flush = 1'b0; drive(1'b0, 64'd0);
        chk("fl_valid", {63'b0, out_valid}, 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_occ0", 64'(occupancy), 64'd0);
        chk("fl_ready", {63'b0, in_ready}, 64'd1);
        chk("fl_stall_kept", 64'(stall_cnt), 64'd15);
        drive(1'b1, 64'h12); step();
        drive(1'b1, 64'hD); flush = 1'b1;
        step();
        flush = 1'b0; drive(1'b0, 64'd0);
        chk("fl2_occ0", 64'(occupancy), 64'd0);
        out_ready = 1'b1;
        repeat (3) step();
        found = 1'b0;
        foreach (delivered[i]) if (delivered[i] == 64'hD) found = 1'b1;
        chk("fl_no_D", {63'b0, found}, 64'd0);

        // Bubble gating: a live control pattern on idle inputs never reaches out_ctrl.
        in_valid = 1'b0; in_ctrl = 6'b100010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bubble_lit", 64'(out_ctrl), 64'd0);
        end

        // Asynchronous reset while two entries are held.
        out_ready = 1'b0;
        drive(1'b1, 64'h21); step();
        drive(1'b1, 64'h22); step();
        drive(1'b0, 64'd0);
        chk("ar_occ2", 64'(occupancy), 64'd2);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", {63'b0, out_valid}, 64'd0);
        chk("ar_ctrl", 64'(out_ctrl), 64'd0);
        chk("ar_occ", 64'(occupancy), 64'd0);
        chk("ar_ready", {63'b0, in_ready}, 64'd0);
        chk("ar_stall", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        chk("ar_ready_pre_edge", {63'b0, in_ready}, 64'd0);
        step();
        chk("ar_ready_post", {63'b0, in_ready}, 64'd1);
        chk("ar_empty", {63'b0, out_valid}, 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
